// File: rtl/acq_pkg.sv
// Shared types and widths for the acquisition controller.
package acq_pkg;

  localparam int unsigned SW = 12;  // ADC sample width
  localparam int unsigned AW = 9;   // frame-buffer column address width

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } acq_state_t;

endpackage

// File: rtl/trig_detect.sv
// Edge trigger detector: remembers the previous valid sample while enabled
// and flags a threshold crossing. The first valid sample after enable only
// primes the history and can never fire.
module trig_detect
  import acq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          sample_valid,
  input  logic [SW-1:0] sample,
  input  logic [SW-1:0] trig_level,
  input  logic          trig_rising,
  output logic          trig
);

  logic [SW-1:0] prev;
  logic          have_prev;

  // History register; validity is dropped whenever the detector is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= '0;
      have_prev <= 1'b0;
    end else if (!en) begin
      have_prev <= 1'b0;
    end else if (sample_valid) begin
      prev      <= sample;
      have_prev <= 1'b1;
    end
  end

  // Crossing compare against the stored previous sample
  always_comb begin
    trig = 1'b0;
    if (en && sample_valid && have_prev) begin
      if (trig_rising) trig = (prev < trig_level) && (sample >= trig_level);
      else             trig = (prev >= trig_level) && (sample < trig_level);
    end
  end

endmodule

// File: rtl/acq_ctrl.sv
// Oscilloscope-style acquisition controller: arms, waits for an edge trigger,
// captures NPIX decimated samples into a frame buffer, then holds the frame
// until the display acknowledges it.
// Optional feature macro: ACQ_AUTO_TRIG_EN (forced trigger after AUTO_TIMEOUT
// valid samples in ARMED without a real trigger).
module acq_ctrl
  import acq_pkg::*;
#(
  parameter int unsigned NPIX         = 480,
  parameter int unsigned AUTO_TIMEOUT = 5000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic [SW-1:0] sample,
  input  logic [SW-1:0] trig_level,
  input  logic          trig_rising,
  input  logic [15:0]   decim,
  input  logic          arm,
  input  logic          disp_ack,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [SW-1:0] wr_data,
  output logic          frame_rdy,
  output logic [1:0]    state_o,
  output logic          forced
);

  if (NPIX < 1 || NPIX > (1 << AW) || AUTO_TIMEOUT < 1) begin : g_cfg_check
    $error("acq_ctrl: NPIX must be 1..2**AW and AUTO_TIMEOUT at least 1");
  end

  acq_state_t  state, next_state;
  logic        armed_s, capt_s, hold_s;
  logic        trig, to_hit, fire, take, last_take;
  logic [15:0] decim_q, dec_cnt;

  trig_detect u_trig (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (armed_s),
    .sample_valid (sample_valid),
    .sample       (sample),
    .trig_level   (trig_level),
    .trig_rising  (trig_rising),
    .trig         (trig)
  );

`ifdef ACQ_AUTO_TRIG_EN
  localparam int unsigned TW = $clog2(AUTO_TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  // Timeout counter: valid samples seen since entering ARMED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        to_cnt <= '0;
    else if (!armed_s)                 to_cnt <= '0;
    else if (sample_valid && !to_hit)  to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = armed_s && sample_valid && (to_cnt == TW'(AUTO_TIMEOUT - 1));

  // Remember whether the current frame was started by the timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    forced <= 1'b0;
    else if (fire) forced <= !trig;
  end
`else
  assign to_hit = 1'b0;
  assign forced = 1'b0;
`endif

  assign fire      = armed_s && arm && (trig || to_hit);
  assign take      = capt_s && sample_valid && (dec_cnt == decim_q);
  // wr_addr holds the last written column, so the final write is decided one
  // address early, letting the state reach HOLD in the same edge as the write.
  assign last_take = take && (wr_addr == AW'(NPIX - 2));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (arm) next_state = ARMED;
      ARMED: begin
        if (!arm)      next_state = IDLE;
        else if (fire) next_state = (NPIX == 1) ? HOLD : CAPTURE;
      end
      CAPTURE: if (last_take) next_state = HOLD;
      HOLD:    if (disp_ack && frame_rdy) next_state = arm ? ARMED : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State decode
  always_comb begin
    armed_s = (state == ARMED);
    capt_s  = (state == CAPTURE);
    hold_s  = (state == HOLD);
    state_o = state;
  end

  // Write path and decimation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      dec_cnt <= '0;
      decim_q <= '0;
    end else begin
      wr_en <= 1'b0;
      if (fire) begin
        wr_en   <= 1'b1;
        wr_addr <= '0;
        wr_data <= sample;
        dec_cnt <= '0;
        decim_q <= decim;
      end else if (take) begin
        wr_en   <= 1'b1;
        wr_addr <= wr_addr + 1'b1;
        wr_data <= sample;
        dec_cnt <= '0;
      end else if (capt_s && sample_valid) begin
        dec_cnt <= dec_cnt + 16'd1;
      end
    end
  end

  // Frame-ready flag: set after the last column write, cleared by an ack in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  frame_rdy <= 1'b0;
    else if (hold_s && disp_ack && frame_rdy)    frame_rdy <= 1'b0;
    else if (wr_en && wr_addr == AW'(NPIX - 1))  frame_rdy <= 1'b1;
  end

endmodule

// File: tb/tb_acq_ctrl.sv
// Directed bench for acq_ctrl: trigger vector table plus frame-level sequences.
module tb_acq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] sample = '0;
  logic [11:0] trig_level = '0;
  logic        trig_rising = 1'b0;
  logic [15:0] decim = '0;
  logic        arm = 1'b0;
  logic        disp_ack = 1'b0;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [11:0] wr_data;
  logic        frame_rdy;
  logic [1:0]  state_o;
  logic        forced;

  int total = 0;
  int bad = 0;

  acq_ctrl #(.NPIX(480), .AUTO_TIMEOUT(100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .trig_level   (trig_level),
    .trig_rising  (trig_rising),
    .decim        (decim),
    .arm          (arm),
    .disp_ack     (disp_ack),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_rdy    (frame_rdy),
    .state_o      (state_o),
    .forced       (forced)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit rise;
    int lvl;
    int s0;
    int s1;
    bit exp_trig;
  } trig_vec_t;

  trig_vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s);
    sample       = 12'(s);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    arm = 1'b0;
    disp_ack = 1'b0;
    sample_valid = 1'b0;
    decim = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic ack_pulse();
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
  endtask

  function automatic int ramp(input int i);
    return (i * 8) % 4096;
  endfunction

  int nwr, first_data, seq_err, gap_err, space_err, cnt, vcnt, last_v, first_idx;
  bit started, done;

  initial begin
    vecs[0] = '{1, 2048, 2040, 2048, 1};
    vecs[1] = '{1, 2048, 2048, 2050, 0};
    vecs[2] = '{1, 2048,  100, 2047, 0};
    vecs[3] = '{1,    0,    0, 4095, 0};
    vecs[4] = '{1, 4095, 4094, 4095, 1};
    vecs[5] = '{0, 2048, 3000, 1000, 1};
    vecs[6] = '{0, 2048, 1000,  500, 0};
    vecs[7] = '{0, 2048, 4000,  100, 1};

    // Reset values while rst_n is low
    tick();
    tick();
    chk("rst_state", state_o, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_frame_rdy", frame_rdy, 0);
    chk("rst_forced", forced, 0);

    // Trigger compare table: first sample primes, second may fire
    for (int v = 0; v < 8; v++) begin
      do_reset();
      trig_level  = 12'(vecs[v].lvl);
      trig_rising = vecs[v].rise;
      arm = 1'b1;
      tick();
      send(vecs[v].s0);
      chk($sformatf("vec%0d_prime_wr_en", v), wr_en, 0);
      send(vecs[v].s1);
      chk($sformatf("vec%0d_wr_en", v), wr_en, vecs[v].exp_trig);
      chk($sformatf("vec%0d_state", v), state_o, vecs[v].exp_trig ? 2 : 1);
      if (vecs[v].exp_trig) begin
        chk($sformatf("vec%0d_wr_data", v), wr_data, vecs[v].s1);
        chk($sformatf("vec%0d_wr_addr", v), wr_addr, 0);
      end
    end

    // Rising ramp, decim=0
    do_reset();
    trig_level = 12'd2048; trig_rising = 1'b1; decim = 16'd0;
    arm = 1'b1;
    tick();
    nwr = 0; first_data = -1; seq_err = 0; gap_err = 0; started = 0;
    for (int i = 200; i < 800; i++) begin
      send(ramp(i));
      if (wr_en) begin
        if (nwr == 0) first_data = wr_data;
        if (wr_addr != 9'(nwr)) seq_err++;
        started = 1;
        nwr++;
        if (nwr == 480) break;
      end else if (started) gap_err++;
    end
    chk("ramp_writes", nwr, 480);
    chk("ramp_first_data", first_data, 2048);
    chk("ramp_addr_seq_err", seq_err, 0);
    chk("ramp_gap_err", gap_err, 0);
    chk("ramp_state_hold", state_o, 3);
    chk("ramp_rdy_in_last_wr", frame_rdy, 0);
    // Ack coinciding with the final write must be ignored
    ack_pulse();
    chk("ramp_rdy_after_last_wr", frame_rdy, 1);
    chk("ramp_ack_same_cycle_state", state_o, 3);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      send(2048 + k);
      if (wr_en) cnt++;
    end
    chk("hold_no_writes", cnt, 0);
    chk("hold_rdy_kept", frame_rdy, 1);
    ack_pulse();
    chk("ack_arm1_state", state_o, 1);
    chk("ack_arm1_rdy", frame_rdy, 0);
    ack_pulse();
    chk("ack_in_armed_state", state_o, 1);
    chk("ack_in_armed_rdy", frame_rdy, 0);

    // Decimation 3, decim changed mid-frame
    decim = 16'd3;
    nwr = 0; vcnt = 0; last_v = 0; space_err = 0; seq_err = 0; started = 0;
    done = 0;
    for (int i = 200; i < 2500; i++) begin
      send(ramp(i));
      if (started) vcnt++;
      if (wr_en) begin
        if (!started) begin
          started = 1;
          vcnt = 1;
        end else if (vcnt - last_v != 4) space_err++;
        last_v = vcnt;
        if (wr_addr != 9'(nwr)) seq_err++;
        nwr++;
        if (nwr == 10) decim = 16'd0;
        if (nwr == 480) begin
          done = 1;
          break;
        end
      end
    end
    chk("decim_writes", nwr, 480);
    chk("decim_valids_to_last", vcnt, 1917);
    chk("decim_spacing_err", space_err, 0);
    chk("decim_addr_seq_err", seq_err, 0);
    chk("decim_done", done, 1);
    tick();
    chk("decim_rdy", frame_rdy, 1);
    arm = 1'b0;
    ack_pulse();
    chk("ack_arm0_state", state_o, 0);
    chk("ack_arm0_rdy", frame_rdy, 0);

    // Falling edge; arm dropped during CAPTURE must not abort
    trig_level = 12'd2048; trig_rising = 1'b0; decim = 16'd0;
    arm = 1'b1;
    tick();
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      send(4000);
      if (wr_en) cnt++;
    end
    chk("fall_hold4000_writes", cnt, 0);
    send(100);
    chk("fall_trig_wr_en", wr_en, 1);
    chk("fall_trig_data", wr_data, 100);
    chk("fall_trig_addr", wr_addr, 0);
    arm = 1'b0;
    cnt = 0;
    for (int k = 0; k < 600; k++) begin
      send(100);
      if (wr_en) cnt++;
      if (state_o == 2'd3) break;
    end
    chk("fall_rest_writes", cnt, 479);
    chk("fall_last_addr", wr_addr, 479);
    tick();
    chk("fall_rdy", frame_rdy, 1);
    ack_pulse();
    chk("fall_ack_idle", state_o, 0);

    // Constant 4000 never triggers; arm low in ARMED returns to IDLE
    arm = 1'b1;
    tick();
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      send(4000);
      if (wr_en) cnt++;
    end
    chk("const_no_writes", cnt, 0);
    chk("const_state_armed", state_o, 1);
    arm = 1'b0;
    tick();
    chk("arm_drop_idle", state_o, 0);

    // Asynchronous reset in the middle of a frame
    do_reset();
    trig_level = 12'd2048; trig_rising = 1'b1; decim = 16'd0;
    arm = 1'b1;
    tick();
    nwr = 0;
    for (int i = 200; i < 800; i++) begin
      send(ramp(i));
      if (wr_en) nwr++;
      if (nwr == 200) break;
    end
    chk("areset_reached_200", nwr, 200);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_state", state_o, 0);
    chk("areset_wr_en", wr_en, 0);
    chk("areset_wr_addr", wr_addr, 0);
    chk("areset_wr_data", wr_data, 0);
    chk("areset_frame_rdy", frame_rdy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 90; k++) begin
      send(1000);
      if (frame_rdy || wr_en) cnt++;
    end
    chk("areset_no_frame_after", cnt, 0);

    // Auto trigger on a flat input
    do_reset();
    trig_level = 12'd2048; trig_rising = 1'b1; decim = 16'd0;
    arm = 1'b1;
    tick();
    first_idx = 0;
    for (int k = 1; k <= 150; k++) begin
      send(1000);
      if (wr_en && first_idx == 0) begin
        first_idx = k;
        break;
      end
    end
`ifdef ACQ_AUTO_TRIG_EN
    chk("auto_trig_index", first_idx, 100);
    chk("auto_forced", forced, 1);
    for (int k = 0; k < 600; k++) begin
      if (state_o == 2'd3) break;
      send(1000);
    end
    chk("auto_frame_hold", state_o, 3);
    tick();
    ack_pulse();
    send(1000);
    send(2048);
    chk("real_trig_wr_en", wr_en, 1);
    chk("real_trig_forced", forced, 0);
`else
    chk("noauto_no_trig", first_idx, 0);
    chk("noauto_state_armed", state_o, 1);
    chk("noauto_forced", forced, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
